quad_decoder: RTL
=================

QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 SHALL have parameter POS_WIDTH, default 32, position counter width in bits.
REQ-002 SHALL have parameter FILT_LEN, default 4, glitch-filter stability count in clocks (range 1..15).
REQ-003 SHALL have port clk_i  input  1  system clock; one clock, all logic on rising edge.
REQ-004 SHALL have port reset_n_i  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port a_i  input  1  quadrature channel A, asynchronous to clk_i.
REQ-006 SHALL have port b_i  input  1  quadrature channel B, asynchronous to clk_i.
REQ-007 SHALL have port z_i  input  1  index pulse, asynchronous to clk_i.
REQ-008 SHALL have port enable_i  input  1  counting enable, synchronous.
REQ-009 SHALL have port rst_on_z_i  input  1  zero position on Z rising edge when high.
REQ-010 SHALL have port setp_i  input  POS_WIDTH  position preset value.
REQ-011 SHALL have port setp_wstb_i  input  1  one-cycle strobe loading setp_i.
REQ-012 SHALL have port err_clr_i  input  1  one-cycle strobe clearing err_o.
REQ-013 SHALL have port posn_o  output  POS_WIDTH  decoded position, registered.
REQ-014 SHALL have port step_o  output  1  one-cycle pulse per counted step.
REQ-015 SHALL have port dir_o  output  1  direction of last counted step, 1 = up.
REQ-016 SHALL have port err_o  output  1  sticky illegal-transition flag.

Function
REQ-017 SHALL pass a_i, b_i, z_i each through a 2-flop synchronizer before any use.
REQ-018 SHALL run a two-state FSM, INIT and TRACK: INIT loads prev={A,B} from the first synchronized sample without counting, then moves to TRACK.
REQ-019 SHALL, in TRACK, decode {A,B}: 00->10->11->01->00 = +1; the reverse sequence = -1; no change = no action.
REQ-020 SHALL treat a two-bit change (00<->11, 10<->01) as illegal: posn_o unchanged, step_o low, err_o set.
REQ-021 SHALL update prev every TRACK cycle regardless of enable_i, so re-enable never produces a spurious count.
REQ-022 SHALL, while enable_i is low, hold posn_o and keep step_o low; illegal transitions still set err_o.
REQ-023 SHALL wrap posn_o modulo 2^POS_WIDTH: all-ones +1 -> 0, 0 -1 -> all-ones, with no error.
REQ-024 SHALL pulse step_o for exactly one cycle, coincident with the posn_o update, and set dir_o in that same cycle.
REQ-025 SHALL give latency, without filter, of an a_i change sampled at edge k to posn_o updated after edge k+3.
REQ-026 SHALL resolve simultaneous events by priority: setp_wstb_i > Z zero (rst_on_z_i high, synchronized Z rising edge) > count step; a displaced step is discarded with step_o low.
REQ-027 SHALL apply setp_i to posn_o at the edge after setp_wstb_i is seen high, independent of enable_i.
REQ-028 SHALL have err_o set win over a same-cycle err_clr_i.

Reset
REQ-029 SHALL, on reset_n_i low, immediately clear posn_o, step_o, dir_o, err_o, synchronizers, filter state and prev, and enter INIT.
REQ-030 SHALL abandon any in-progress step on reset mid-operation; after release the first sample re-enters via INIT with no count.

Configuration
REQ-031 SHALL, with QDEC_GLITCH_FILTER_EN defined, filter each synchronized A/B/Z: the filtered value takes a new level only after FILT_LEN consecutive cycles differing from it; shorter pulses are discarded; latency becomes edge k+3+FILT_LEN.
REQ-032 SHALL, without QDEC_GLITCH_FILTER_EN, contain no filter logic and use synchronized inputs directly.

Verification
REQ-033 SHALL verify: reset, enable=1, 8 forward A/B cycles (32 transitions, 20 clocks apart) -> posn_o=32, 32 step_o pulses, dir_o=1, err_o=0.
REQ-034 SHALL verify: setp=0xFFFFFFFE strobed, 3 forward transitions -> posn_o 0xFFFFFFFF, 0x0, 0x1; then 2 reverse -> 0x0, 0xFFFFFFFF.
REQ-035 SHALL verify: AB jumps 00->11 -> posn_o unchanged, err_o=1; err_clr_i pulse -> err_o=0; error and clear same cycle -> err_o=1.
REQ-036 SHALL verify: setp_wstb_i (setp=100) and Z rising edge with rst_on_z_i=1 in the same cycle as a step -> posn_o=100, step_o=0.
REQ-037 SHALL verify: enable=0, 4 transitions, enable=1, 1 forward transition -> posn_o increments by exactly 1.
REQ-038 SHALL verify: with QDEC_GLITCH_FILTER_EN, FILT_LEN=4: 3-cycle A glitch -> no count; 5-cycle stable change -> count after edge k+7.

Source files
------------

// File: rtl/quad_decoder.sv
// Quadrature (A/B/Z) decoder with 2-flop synchronizers and a wrapping position counter.
// Optional per-channel glitch filter enabled by defining QDEC_GLITCH_FILTER_EN.
module quad_decoder #(
  parameter int unsigned POS_WIDTH = 32,
  parameter int unsigned FILT_LEN  = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 a_i,
  input  logic                 b_i,
  input  logic                 z_i,
  input  logic                 enable_i,
  input  logic                 rst_on_z_i,
  input  logic [POS_WIDTH-1:0] setp_i,
  input  logic                 setp_wstb_i,
  input  logic                 err_clr_i,
  output logic [POS_WIDTH-1:0] posn_o,
  output logic                 step_o,
  output logic                 dir_o,
  output logic                 err_o
);

  typedef enum logic {StInit, StTrack} state_e;

  localparam logic [POS_WIDTH-1:0] PosOne = {{(POS_WIDTH-1){1'b0}}, 1'b1};

  // Channel vectors are ordered {A, B, Z}.
  logic [2:0] sync1_q, sync2_q, cur_q;
  logic       sv1_q, sv2_q, cur_vld_q;
  logic [2:0] use_d;
  logic       use_vld_d;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cur_q     <= '0;
      sv1_q     <= 1'b0;
      sv2_q     <= 1'b0;
      cur_vld_q <= 1'b0;
    end else begin
      sync1_q   <= {a_i, b_i, z_i};
      sync2_q   <= sync1_q;
      sv1_q     <= 1'b1;
      sv2_q     <= sv1_q;
      cur_q     <= use_d;
      cur_vld_q <= use_vld_d;
    end
  end

`ifdef QDEC_GLITCH_FILTER_EN
  localparam logic [3:0] FiltMax = 4'(FILT_LEN - 1);

  logic [2:0]      filt_q;
  logic            filt_vld_q;
  logic [2:0][3:0] cnt_q;

  // The first valid synchronized sample seeds the filter so start-up levels pass unfiltered.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      filt_q     <= '0;
      filt_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else if (sv2_q) begin
      if (!filt_vld_q) begin
        filt_q     <= sync2_q;
        filt_vld_q <= 1'b1;
        cnt_q      <= '0;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (sync2_q[i] == filt_q[i]) begin
            cnt_q[i] <= '0;
          end else if (cnt_q[i] == FiltMax) begin
            filt_q[i] <= sync2_q[i];
            cnt_q[i]  <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 4'd1;
          end
        end
      end
    end
  end

  assign use_d     = filt_q;
  assign use_vld_d = filt_vld_q;
`else
  assign use_d     = sync2_q;
  assign use_vld_d = sv2_q;
`endif

  state_e                 state_q;
  logic [1:0]             prev_q;
  logic                   z_prev_q;
  logic [POS_WIDTH-1:0]   posn_q;
  logic                   step_q, dir_q, err_q;

  logic [1:0] cur_ab, diff;
  logic       mv_up, mv_dn, illegal, z_rise;

  // Position of an {A,B} code along the forward Gray sequence 00,10,11,01.
  function automatic logic [1:0] ab_idx(input logic [1:0] ab);
    logic [1:0] idx;
    unique case (ab)
      2'b00:   idx = 2'd0;
      2'b10:   idx = 2'd1;
      2'b11:   idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  always_comb begin
    cur_ab  = cur_q[2:1];
    diff    = ab_idx(cur_ab) - ab_idx(prev_q);
    mv_up   = (diff == 2'd1);
    mv_dn   = (diff == 2'd3);
    illegal = (diff == 2'd2);
    z_rise  = cur_q[0] & ~z_prev_q;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= StInit;
      prev_q   <= '0;
      z_prev_q <= 1'b0;
      posn_q   <= '0;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      step_q <= 1'b0;
      case (state_q)
        StInit: begin
          if (cur_vld_q) begin
            prev_q   <= cur_ab;
            z_prev_q <= cur_q[0];
            state_q  <= StTrack;
          end
        end
        StTrack: begin
          prev_q   <= cur_ab;
          z_prev_q <= cur_q[0];
          if (setp_wstb_i) begin
            posn_q <= setp_i;
          end else if (rst_on_z_i && z_rise) begin
            posn_q <= '0;
          end else if (enable_i && (mv_up || mv_dn)) begin
            posn_q <= mv_up ? posn_q + PosOne : posn_q - PosOne;
            step_q <= 1'b1;
            dir_q  <= mv_up;
          end
        end
        default: state_q <= StInit;
      endcase
      // Preset also applies before tracking has started.
      if (setp_wstb_i) posn_q <= setp_i;
      if (state_q == StTrack && illegal) begin
        err_q <= 1'b1;
      end else if (err_clr_i) begin
        err_q <= 1'b0;
      end
    end
  end

  assign posn_o = posn_q;
  assign step_o = step_q;
  assign dir_o  = dir_q;
  assign err_o  = err_q;

endmodule
